// File: rtl/shot_pool_manager.sv
// Pool of player projectiles: fire control (cooldown, magazine, reload), per-slot motion,
// collision release and a registered draw stage merging all slots into one pixel.
module shot_pool_manager #(
  parameter int unsigned NUM_SHOTS       = 4,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned MAG_SIZE        = 8,
  parameter int unsigned RELOAD_FRAMES   = 60,
  parameter int unsigned SHOT_W          = 4,
  parameter int unsigned SHOT_H          = 8,
  parameter int unsigned SHOT_SPEED      = 4,
  parameter int unsigned SPAWN_DX        = 14,
  parameter logic [7:0]  SHOT_COLOR      = 8'h5B
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic                            pause,
  input  logic                            trigger,
  input  logic [10:0]                     player_tpX,
  input  logic [10:0]                     player_tpY,
  input  logic [NUM_SHOTS-1:0]            shotHit,
  input  logic [10:0]                     pixelX,
  input  logic [10:0]                     pixelY,
  output logic [NUM_SHOTS-1:0]            slotReq,
  output logic                            drawingRequest,
  output logic [10:0]                     offsetX,
  output logic [10:0]                     offsetY,
  output logic [7:0]                      RGB_OUT,
  output logic [$clog2(MAG_SIZE+1)-1:0]   ammo,
  output logic                            reloading,
  output logic                            fired,
  output logic                            denied
);

  localparam int unsigned AW = $clog2(MAG_SIZE + 1);
  localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 2);
  localparam int unsigned RW = $clog2(RELOAD_FRAMES + 1);

  logic [NUM_SHOTS-1:0] r_active;
  logic [10:0]          r_x [NUM_SHOTS];
  logic [10:0]          r_y [NUM_SHOTS];
  logic [AW-1:0]        r_ammo;
  logic [CW-1:0]        r_cool;
  logic [RW-1:0]        r_reload_cnt;
  logic                 r_reloading;
  logic                 r_fired;
  logic                 r_denied;

  logic [NUM_SHOTS-1:0] r_slot_req;
  logic                 r_draw;
  logic [10:0]          r_ox;
  logic [10:0]          r_oy;
  logic [7:0]           r_rgb;

  logic [NUM_SHOTS-1:0] w_free_oh;
  logic                 w_free_any;
  logic                 w_step;
  logic                 w_want;
  logic                 w_accept;
  logic [10:0]          w_spawn_x;
  logic [10:0]          w_spawn_y;
  logic [NUM_SHOTS-1:0] w_req;
  logic                 w_sel_hit;
  logic [10:0]          w_sel_ox;
  logic [10:0]          w_sel_oy;

  // Lowest-index free slot, searched on current state only.
  always_comb begin
    w_free_oh  = '0;
    w_free_any = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!r_active[i] && !w_free_any) begin
        w_free_oh[i] = 1'b1;
        w_free_any   = 1'b1;
      end
    end
  end

  assign w_step    = startOfFrame && !pause;
  assign w_want    = trigger && !pause && (r_cool == '0);
  assign w_accept  = w_want && !r_reloading && (r_ammo != '0) && w_free_any &&
                     (player_tpY >= 11'(SHOT_H));
  assign w_spawn_x = player_tpX + 11'(SPAWN_DX);
  assign w_spawn_y = player_tpY - 11'(SHOT_H);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_active <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (shotHit[i] && r_active[i]) begin
          r_active[i] <= 1'b0;
        end else if (w_accept && w_free_oh[i]) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= w_spawn_x;
          r_y[i]      <= w_spawn_y;
        end else if (w_step && r_active[i]) begin
          // A shot that cannot take a full step has left the top of the screen.
          if (r_y[i] >= 11'(SHOT_SPEED)) begin
            r_y[i] <= r_y[i] - 11'(SHOT_SPEED);
          end else begin
            r_active[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ammo       <= AW'(MAG_SIZE);
      r_cool       <= '0;
      r_reload_cnt <= '0;
      r_reloading  <= 1'b0;
      r_fired      <= 1'b0;
      r_denied     <= 1'b0;
    end else begin
      r_fired  <= w_accept;
      r_denied <= w_want && !w_accept;
      if (w_accept) begin
        r_cool <= CW'(COOLDOWN_FRAMES);
      end else if (w_step && (r_cool != '0)) begin
        r_cool <= r_cool - 1'b1;
      end
      if (w_accept) begin
        r_ammo <= r_ammo - 1'b1;
        if (r_ammo == AW'(1)) begin
          r_reloading  <= 1'b1;
          r_reload_cnt <= RW'(RELOAD_FRAMES);
        end
      end else if (r_reloading && w_step) begin
        if (r_reload_cnt == RW'(1)) begin
          r_ammo       <= AW'(MAG_SIZE);
          r_reloading  <= 1'b0;
          r_reload_cnt <= '0;
        end else begin
          r_reload_cnt <= r_reload_cnt - 1'b1;
        end
      end
    end
  end

  // 12-bit compares so a shot near X=2047 does not wrap onto the left edge.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      w_req[i] = r_active[i] &&
                 ({1'b0, pixelX} >= {1'b0, r_x[i]}) &&
                 ({1'b0, pixelX} < ({1'b0, r_x[i]} + 12'(SHOT_W))) &&
                 ({1'b0, pixelY} >= {1'b0, r_y[i]}) &&
                 ({1'b0, pixelY} < ({1'b0, r_y[i]} + 12'(SHOT_H)));
    end
  end

  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_ox  = '0;
    w_sel_oy  = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (w_req[i] && !w_sel_hit) begin
        w_sel_hit = 1'b1;
        w_sel_ox  = pixelX - r_x[i];
        w_sel_oy  = pixelY - r_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_slot_req <= '0;
      r_draw     <= 1'b0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_rgb      <= 8'hFF;
    end else begin
      r_slot_req <= w_req;
      r_draw     <= w_sel_hit;
      r_ox       <= w_sel_ox;
      r_oy       <= w_sel_oy;
      r_rgb      <= w_sel_hit ? SHOT_COLOR : 8'hFF;
    end
  end

  assign slotReq        = r_slot_req;
  assign drawingRequest = r_draw;
  assign offsetX        = r_ox;
  assign offsetY        = r_oy;
  assign RGB_OUT        = r_rgb;
  assign ammo           = r_ammo;
  assign reloading      = r_reloading;
  assign fired          = r_fired;
  assign denied         = r_denied;

endmodule

// File: tb/tb_shot_pool_manager.sv
// Bench for shot_pool_manager: directed scenarios then random traffic, all cycles checked
// against a slot/magazine reference model.
module tb_shot_pool_manager;

  localparam int NS = 4;
  localparam int CD = 15;
  localparam int MAG = 8;
  localparam int RL = 60;
  localparam int SW = 4;
  localparam int SH = 8;
  localparam int SP = 4;
  localparam int DX = 14;
  localparam int COL = 'h5B;

  logic clk = 1'b0;
  logic resetN, startOfFrame, pause, trigger;
  logic [10:0] player_tpX, player_tpY, pixelX, pixelY;
  logic [NS-1:0] shotHit, slotReq;
  logic drawingRequest;
  logic [10:0] offsetX, offsetY;
  logic [7:0] RGB_OUT;
  logic [3:0] ammo;
  logic reloading, fired, denied;

  int total = 0;
  int bad = 0;

  int m_act[NS];
  int m_x[NS];
  int m_y[NS];
  int m_ammo, m_cool, m_rel, m_rcnt;
  int e_req, e_ox, e_oy, e_rgb, e_fired, e_denied;

  shot_pool_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
    .trigger(trigger), .player_tpX(player_tpX), .player_tpY(player_tpY),
    .shotHit(shotHit), .pixelX(pixelX), .pixelY(pixelY), .slotReq(slotReq),
    .drawingRequest(drawingRequest), .offsetX(offsetX), .offsetY(offsetY),
    .RGB_OUT(RGB_OUT), .ammo(ammo), .reloading(reloading), .fired(fired), .denied(denied)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s wait expired got=timeout exp=done", tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_ammo = MAG; m_cool = 0; m_rel = 0; m_rcnt = 0;
    e_req = 0; e_ox = 0; e_oy = 0; e_rgb = 'hFF; e_fired = 0; e_denied = 0;
  endtask

  // Next-state of the model from current state and the inputs about to be sampled.
  task automatic model_edge();
    int fi, px, py;
    bit want, ok, mv;
    px = int'(pixelX);
    py = int'(pixelY);
    e_req = 0; e_ox = 0; e_oy = 0; e_rgb = 'hFF;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + SW && py >= m_y[i] &&
          py < m_y[i] + SH) begin
        if (e_req == 0) begin
          e_ox = px - m_x[i]; e_oy = py - m_y[i]; e_rgb = COL;
        end
        e_req = e_req | (1 << i);
      end
    end
    fi = -1;
    for (int i = 0; i < NS; i++) if (m_act[i] == 0 && fi < 0) fi = i;
    want = trigger && !pause && m_cool == 0;
    ok = want && m_rel == 0 && m_ammo > 0 && fi >= 0 && int'(player_tpY) >= SH;
    e_fired = ok;
    e_denied = want && !ok;
    mv = startOfFrame && !pause;
    for (int i = 0; i < NS; i++) begin
      if (shotHit[i] && m_act[i] != 0) m_act[i] = 0;
      else if (ok && i == fi) begin
        m_act[i] = 1;
        m_x[i] = (int'(player_tpX) + DX) % 2048;
        m_y[i] = int'(player_tpY) - SH;
      end else if (mv && m_act[i] != 0) begin
        if (m_y[i] >= SP) m_y[i] = m_y[i] - SP;
        else m_act[i] = 0;
      end
    end
    if (ok) m_cool = CD;
    else if (mv && m_cool > 0) m_cool--;
    if (ok) begin
      m_ammo--;
      if (m_ammo == 0) begin m_rel = 1; m_rcnt = RL; end
    end else if (m_rel != 0 && mv) begin
      if (m_rcnt == 1) begin m_ammo = MAG; m_rel = 0; m_rcnt = 0; end
      else m_rcnt--;
    end
  endtask

  task automatic compare_all();
    check("slotReq", slotReq, e_req);
    check("drawingRequest", drawingRequest, (e_req != 0));
    check("offsetX", offsetX, e_ox);
    check("offsetY", offsetY, e_oy);
    check("RGB_OUT", RGB_OUT, e_rgb);
    check("ammo", ammo, m_ammo);
    check("reloading", reloading, m_rel);
    check("fired", fired, e_fired);
    check("denied", denied, e_denied);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slotReq"}, slotReq, 0);
    check({tag, "_draw"}, drawingRequest, 0);
    check({tag, "_ox"}, offsetX, 0);
    check({tag, "_oy"}, offsetY, 0);
    check({tag, "_rgb"}, RGB_OUT, 'hFF);
    check({tag, "_ammo"}, ammo, MAG);
    check({tag, "_reloading"}, reloading, 0);
    check({tag, "_fired"}, fired, 0);
    check({tag, "_denied"}, denied, 0);
  endtask

  // Run frames until cooldown is over and the magazine is usable.
  task automatic wait_ready(input string tag);
    int g = 0;
    trigger = 1'b0;
    while ((m_cool != 0 || m_rel != 0) && g < 1000) begin
      startOfFrame = (g % 2 == 0);
      step();
      g++;
    end
    startOfFrame = 1'b0;
    if (m_cool != 0 || m_rel != 0) timeout_fail(tag);
  endtask

  task automatic fire_one();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic free_all();
    shotHit = '1;
    step();
    shotHit = '0;
  endtask

  int probe_x[6] = '{114, 117, 118, 114, 113, 114};
  int probe_y[6] = '{192, 199, 199, 200, 192, 191};
  int probe_r[6] = '{1, 1, 0, 0, 0, 0};
  int probe_ox[6] = '{0, 3, 0, 0, 0, 0};
  int probe_oy[6] = '{0, 7, 0, 0, 0, 0};

  initial begin
    int nf, nd, g, j;
    resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0; trigger = 1'b0;
    player_tpX = '0; player_tpY = '0; shotHit = '0; pixelX = '0; pixelY = '0;
    model_reset();
    #23;
    check_reset_outputs("reset");
    #4 resetN = 1'b1;

    // Single shot from (100,200) and its draw box.
    player_tpX = 11'd100; player_tpY = 11'd200;
    fire_one();
    check("t1_fired", fired, 1);
    check("t1_ammo", ammo, 7);
    for (int k = 0; k < 6; k++) begin
      pixelX = 11'(probe_x[k]); pixelY = 11'(probe_y[k]);
      step();
      check("t1_probe_req", slotReq, probe_r[k]);
      check("t1_probe_ox", offsetX, probe_ox[k]);
      check("t1_probe_oy", offsetY, probe_oy[k]);
      check("t1_probe_rgb", RGB_OUT, probe_r[k] != 0 ? COL : 'hFF);
    end

    // Held trigger for 40 frames: only cooldown-paced accepts, never denied.
    nf = 0; nd = 0;
    trigger = 1'b1;
    for (int k = 0; k < 120; k++) begin
      startOfFrame = (k % 3 == 2);
      step();
      nf += int'(fired);
      nd += int'(denied);
    end
    trigger = 1'b0; startOfFrame = 1'b0;
    check("t2_fired_count", nf, 2);
    check("t2_denied_count", nd, 0);

    // Empty the magazine, refused while reloading, refilled afterwards.
    g = 0;
    trigger = 1'b1;
    while (m_rel == 0 && g < 2000) begin
      startOfFrame = (g % 2 == 0);
      step();
      g++;
    end
    trigger = 1'b0; startOfFrame = 1'b0;
    if (m_rel == 0) timeout_fail("t3_drain");
    check("t3_ammo_empty", ammo, 0);
    check("t3_reloading", reloading, 1);
    g = 0;
    while (m_cool != 0 && g < 500) begin
      startOfFrame = (g % 2 == 0);
      step();
      g++;
    end
    startOfFrame = 1'b0;
    fire_one();
    check("t3_denied_reload", denied, 1);
    wait_ready("t3_reload");
    check("t3_ammo_full", ammo, MAG);
    check("t3_reload_done", reloading, 0);

    // Fill all slots, refused when full, a hit frees slot 2 for the next shot.
    free_all();
    player_tpX = 11'd300; player_tpY = 11'd1000;
    for (int s = 0; s < NS; s++) begin
      wait_ready("t4_ready");
      fire_one();
      check("t4_fire", fired, 1);
    end
    wait_ready("t4_ready_full");
    fire_one();
    check("t4_full_denied", denied, 1);
    shotHit = 4'b0100;
    step();
    shotHit = '0;
    fire_one();
    check("t4_refire", fired, 1);
    pixelX = 11'(m_x[2]); pixelY = 11'(m_y[2]);
    step();
    check("t4_slot2_req", slotReq, 4'b0100);

    // Low spawn, exit off the top, low player refused, pause freezes everything.
    free_all();
    player_tpX = 11'd50;
    wait_ready("t5_ready");
    player_tpY = 11'd7;
    fire_one();
    check("t5_low_denied", denied, 1);
    player_tpY = 11'd13;
    fire_one();
    check("t5_fire", fired, 1);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    pixelX = 11'd64; pixelY = 11'd1;
    step();
    check("t5_y1_req", slotReq, 4'b0001);
    pixelY = 11'd8;
    step();
    check("t5_y1_bottom_oy", offsetY, 7);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    pixelY = 11'd1;
    step();
    check("t5_gone", slotReq, 0);
    player_tpY = 11'd600;
    wait_ready("t5_ready2");
    fire_one();
    nf = 0;
    pause = 1'b1; trigger = 1'b1;
    for (int k = 0; k < 20; k++) begin
      startOfFrame = (k % 2 == 0);
      step();
      nf += int'(fired) + int'(denied);
    end
    pause = 1'b0; trigger = 1'b0; startOfFrame = 1'b0;
    check("t5_pause_quiet", nf, 0);
    pixelX = 11'(m_x[0] + 1); pixelY = 11'(m_y[0] + 1);
    step();
    check("t5_pause_pos", slotReq, 4'b0001);

    // Slots 1 and 3 stacked on the same spot; slot 1 wins the merged pixel.
    free_all();
    player_tpY = 11'd1000;
    player_tpX = 11'd500; wait_ready("t6_a"); fire_one();
    player_tpX = 11'd86;  wait_ready("t6_b"); fire_one();
    player_tpX = 11'd700; wait_ready("t6_c"); fire_one();
    player_tpX = 11'd86;  wait_ready("t6_d");
    player_tpY = 11'(m_y[1] + SH);
    fire_one();
    pixelX = 11'd101; pixelY = 11'(m_y[1] + 2);
    step();
    check("t6_overlap_req", slotReq, 4'b1010);
    check("t6_overlap_ox", offsetX, 1);
    check("t6_overlap_oy", offsetY, 2);
    check("t6_overlap_rgb", RGB_OUT, COL);

    // Asynchronous reset away from the clock edge.
    #3 resetN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    #2 resetN = 1'b1;

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      trigger = ($urandom % 3 != 0);
      pause = ($urandom % 10 == 0);
      startOfFrame = ($urandom % 3 == 0);
      shotHit = ($urandom % 12 == 0) ? NS'($urandom) : '0;
      player_tpX = ($urandom % 4 == 0) ? 11'(2040 + $urandom % 8) : 11'($urandom % 2048);
      player_tpY = ($urandom % 6 == 0) ? 11'($urandom % 12) : 11'($urandom % 400);
      j = $urandom % NS;
      if (m_act[j] != 0) begin
        pixelX = 11'(m_x[j] + int'($urandom % 7) - 2);
        pixelY = 11'(m_y[j] + int'($urandom % 11) - 2);
      end else begin
        pixelX = 11'($urandom % 2048);
        pixelY = 11'($urandom % 512);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
